hack_screen_arbiter: RTL
========================

# hack_screen_arbiter

Shares the single-port screen RAM between the Hack CPU data bus and the VGA pixel fetcher. CPU accesses always win the RAM port and never stall. Idle RAM cycles prefetch screen words in raster order into a small show-ahead FIFO, which the VGA controller pops. The block sits between the address decoder/CPU, the screen RAM instance and `hack_vga_top`.

## Interface
- `DW`, 16: data width.
- `AW`, 13: screen RAM address width.
- `WORDS`, 8192: screen words per frame; fetch address wraps after `WORDS-1`.
- `DEPTH`, 8: prefetch FIFO depth, a power of two and ≥ 2.
- `clk`  in  1  system/pixel clock; the only clock in the block.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `cpu_sel`  in  1  CPU addresses screen RAM this cycle.
- `cpu_write`  in  1  write qualifier, valid with `cpu_sel`.
- `cpu_addr`  in  AW  CPU word address (already offset from 16384).
- `cpu_wdata`  in  DW  CPU write data.
- `cpu_rdata`  out  DW  read data, valid the cycle after a `cpu_sel` read.
- `ram_addr`  out  AW  RAM address.
- `ram_write`  out  1  RAM write enable.
- `ram_wdata`  out  DW  RAM write data.
- `ram_rdata`  in  DW  RAM read data, 1-cycle latency.
- `vga_start`  in  1  frame-start pulse: flush and restart fetch at word 0.
- `vga_pop`  in  1  consume the FIFO head.
- `vga_valid`  out  1  FIFO not empty.
- `vga_rdata`  out  DW  FIFO head word (show-ahead).
- `fifo_level`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `underflow`  out  1  sticky; set when `vga_pop` is seen while empty.

## Operation
- **Port mux (combinational):**
  - If `cpu_sel=1`: `ram_addr=cpu_addr`, `ram_write=cpu_write`, `ram_wdata=cpu_wdata`.
  - Else, if a fetch is issued: `ram_addr=fetch_addr`, `ram_write=0`.
  - Else: `ram_addr=fetch_addr`, `ram_write=0`, no fetch.
- **Fetch issue:** a fetch is issued when `!cpu_sel && !vga_start && (level + pend) < DEPTH`.
  - `pend` is a 1-bit flag for a fetch in flight.
  - On issue: `fetch_addr` increments; it wraps from `WORDS-1` to 0.
- **Fetch return:** the cycle after an issue, `pend=1` pushes `ram_rdata` into the FIFO.
- **CPU read data:** `cpu_rdata = ram_rdata` directly. The CPU-side read mux qualifies it with its own registered select.
- **Pop:** `vga_pop && vga_valid` removes the head. Push and pop in the same cycle keep the level unchanged.
- **Empty pop:** `vga_pop` while empty sets `underflow`. Level, pointers and `vga_rdata` are unchanged.
- **`vga_start` (highest priority), in one cycle:**
  - FIFO pointers and level clear; `fetch_addr` becomes 0.
  - `pend` clears, so an in-flight word is dropped.
  - Any pop in the same cycle is ignored. No fetch issues that cycle.
- **`underflow` clearing:** cleared only by reset.
- **Level accounting:** the `level + pend < DEPTH` rule guarantees no overflow. A push into a full FIFO cannot occur; the bench asserts this.

## Timing
- **Reset values:**
  - `ram_write=0`, `fetch_addr=0`, `pend=0`.
  - `vga_valid=0`, `fifo_level=0`, `underflow=0`.
  - `vga_rdata=0` (storage cleared).
  - `ram_addr`/`ram_wdata` follow the mux with `cpu_sel` low.
- **Fill latency:** a fetch issued in cycle N is in the FIFO at the edge ending cycle N+1. `vga_valid` rises in cycle N+2.
- **After `vga_start` or reset release:** first issue at cycle 1; `vga_valid` at cycle 3.
- **Sustained fetch:** with no CPU traffic, fetch throughput is 1 word/cycle until `level + pend = DEPTH`.
- **CPU writes:** reach RAM the same cycle as `cpu_sel`. A CPU write to a word already prefetched is not reflected in the FIFO; the update shows on the next frame.
- **Reset mid-fetch:** an asynchronous reset during a fetch discards everything. The first fetch after release is word 0.

## Test plan
- **Reset/idle fill:** release reset, no CPU, no pops.
  - Issues on cycles 1..8 at addresses 0..7.
  - `fifo_level` reaches 8; issue stops; `vga_valid=1`; `vga_rdata` = mem[0].
- **CPU priority:** with the FIFO draining, hold `cpu_sel=1`, `cpu_write=1`, `cpu_addr=0x0100`, `wdata=0xBEEF` for 3 cycles.
  - RAM sees only CPU traffic; `fetch_addr` is frozen.
  - A later CPU read of 0x0100 returns 0xBEEF one cycle later.
- **Streaming/wrap:** pop every cycle for 8200 pops.
  - Popped words equal mem[0..8191] then mem[0..7].
  - No `underflow`, given no CPU traffic.
- **Frame restart:** assert `vga_start` while `pend=1` and level=5.
  - Next cycle: level=0 and no push of the stale word.
  - The following fetches are addresses 0,1,2...
- **Underflow:** hold `cpu_sel=1` continuously and pop 9 times.
  - 8 pops return data; the 9th sets `underflow=1` with `vga_rdata` and level unchanged.
  - `underflow` stays 1 until `reset=0`.
- **Simultaneous push+pop at level 8:** drain one word, then pop each cycle with fetches active.
  - Level holds at 7/8 and never exceeds `DEPTH`; data order is preserved.

Source files
------------

// File: rtl/hack_screen_arbiter.sv
// Screen RAM port arbiter: the CPU always owns the RAM port, and idle cycles prefetch
// screen words in raster order into a show-ahead FIFO that the VGA side pops.
module hack_screen_arbiter #(
  parameter int DW    = 16,
  parameter int AW    = 13,
  parameter int WORDS = 8192,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cpu_sel,
  input  logic                     cpu_write,
  input  logic [AW-1:0]            cpu_addr,
  input  logic [DW-1:0]            cpu_wdata,
  output logic [DW-1:0]            cpu_rdata,
  output logic [AW-1:0]            ram_addr,
  output logic                     ram_write,
  output logic [DW-1:0]            ram_wdata,
  input  logic [DW-1:0]            ram_rdata,
  input  logic                     vga_start,
  input  logic                     vga_pop,
  output logic                     vga_valid,
  output logic [DW-1:0]            vga_rdata,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     underflow
);

  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] fifo_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   level;
  logic [AW-1:0] fetch_addr;
  logic          pend;
  logic [PW+1:0] occupancy;
  logic          issue;
  logic          push;
  logic          pop;

  // Counting the in-flight word against capacity means a returning fetch always has a slot.
  assign occupancy = {1'b0, level} + {{(PW+1){1'b0}}, pend};
  assign issue     = !cpu_sel && !vga_start && (occupancy < (PW+2)'(DEPTH));
  assign push      = pend && !vga_start;
  assign pop       = vga_pop && !vga_start && (level != '0);

  always_comb begin
    ram_addr  = fetch_addr;
    ram_write = 1'b0;
    ram_wdata = cpu_wdata;
    if (cpu_sel) begin
      ram_addr  = cpu_addr;
      ram_write = cpu_write;
    end
  end

  // The CPU-side read mux qualifies this with its own registered select.
  assign cpu_rdata  = ram_rdata;
  assign vga_valid  = (level != '0);
  assign vga_rdata  = fifo_mem[rd_ptr];
  assign fifo_level = level;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_addr <= '0;
      pend       <= 1'b0;
    end else if (vga_start) begin
      fetch_addr <= '0;
      pend       <= 1'b0;
    end else begin
      pend <= issue;
      if (issue) begin
        if (fetch_addr == AW'(WORDS-1)) fetch_addr <= '0;
        else                            fetch_addr <= fetch_addr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (vga_start) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (!push && pop) level <= level - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) fifo_mem[i] <= '0;
    end else if (push) begin
      fifo_mem[wr_ptr] <= ram_rdata;
    end
  end

  // Sticky until reset; a pop coinciding with a frame restart is ignored entirely.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                     underflow <= 1'b0;
    else if (vga_pop && !vga_start && level == '0)  underflow <= 1'b1;
  end

endmodule
